e1_framer_tx: RTL and testbench
===============================

E1_FRAMER_TX -- requirements
Module: e1_framer_tx

Interface
REQ-001 Parameter FAS_WORD, default 8'h1B, frame alignment byte sent in TS0 of even frames.
REQ-002 Parameter NFAS_WORD, default 8'hDF, non-alignment byte sent in TS0 of odd frames.
REQ-003 Parameter IDLE_WORD, default 8'hFF, byte substituted into a payload slot on underrun.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  line bit clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 paralelo  input  8  payload byte for the next timeslot.
REQ-008 valid  input  1  paralelo holds a byte to transfer.
REQ-009 ready  output  1  block accepts paralelo this cycle.
REQ-010 linha  output  1  serial E1 line, one bit per clk.
REQ-011 frame_sync  output  1  high while linha carries bit 0 of TS0.
REQ-012 slot  output  5  timeslot index currently on linha (0..31).
REQ-013 underrun  output  1  one-cycle pulse when IDLE_WORD is loaded for a payload slot.

Function
REQ-014 The frame SHALL be 32 timeslots × 8 bits = 256 clk cycles; bits within a slot SHALL go out LSB first (bit 0 first), matching the existing SIPO receiver.
REQ-015 State SHALL be: 8-bit shift register sreg, 3-bit bit counter bit_cnt, 5-bit slot counter, 1-bit frame parity odd.
REQ-016 linha SHALL equal sreg[0] (registered; no combinational path from inputs).
REQ-017 If bit_cnt != 7: sreg shifts right by one with 1 filled at bit 7, and bit_cnt increments.
REQ-018 If bit_cnt == 7: bit_cnt wraps to 0, slot increments mod 32, and sreg loads the byte for the new slot per REQ-019..REQ-021.
REQ-019 New slot 0: load FAS_WORD if the completing frame is odd (next frame even), else NFAS_WORD; toggle odd; ignore valid.
REQ-020 New slot 1..31 with valid=1: load paralelo; this is the only transfer point.
REQ-021 New slot 1..31 with valid=0: load IDLE_WORD; assert underrun for exactly the following cycle.
REQ-022 ready SHALL be combinational: (bit_cnt == 7) && (slot != 31); transfer occurs iff valid && ready at a rising edge.
REQ-023 Latency: a byte transferred at edge t SHALL appear on linha bit 0 in cycle t+1 through bit 7 in cycle t+8.
REQ-024 valid may be held high without ready; the block SHALL NOT consume data when ready=0, and paralelo need not be stable outside ready.
REQ-025 frame_sync SHALL be (slot == 0) && (bit_cnt == 0), combinational from state.
REQ-026 Slot counter wrap 31->0 SHALL coincide with TS0 load; no dead cycles between frames.

Reset
REQ-027 On rst_n low: sreg = FAS_WORD, bit_cnt = 0, slot = 0, odd = 0, underrun = 0.
REQ-028 Therefore during reset linha = 1, frame_sync = 1, ready = 0, slot = 0.
REQ-029 After release, first frame SHALL be even (FAS in TS0), starting from bit 0 already on linha.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately; any byte in sreg is discarded; no underrun pulse.

Structure
REQ-031 A shared package e1_pkg SHALL hold E1_SLOTS=32, E1_BITS=8, FAS/NFAS/IDLE default constants, and slot index width; parameter defaults SHALL come from it.
REQ-032 One sub-module e1_slot_counter (bit_cnt, slot, odd, wrap strobes) is natural; the serializer and handshake stay in the top.

Verification
REQ-033 Reset then idle (valid=0) for 512 cycles -> TS0 frame0 bits 1,1,0,1,1,0,0,0 (8'h1B LSB first); TS0 frame1 = 8'hDF; every payload slot 8'hFF; 62 underrun pulses.
REQ-034 Source streams bytes 1..31 with valid always 1 -> 31 transfers per frame at bit_cnt==7 of slots 0..30; slot k carries byte k; no underrun.
REQ-035 Single byte 8'hA5 offered at slot 4 bit 7 -> linha shows 1,0,1,0,0,1,0,1 in cycles t+1..t+8; slot output = 5 throughout.
REQ-036 valid held high through slot 31 bit 7 -> ready=0, no transfer, TS0 carries FAS/NFAS, byte accepted one slot later at slot 0 bit 7.
REQ-037 rst_n pulsed low at slot 17 bit 3 -> linha=1, frame_sync=1 immediately; after release next TS0 is FAS and frame count restarts even.
REQ-038 Loopback through the existing SIPO receiver, aligned on frame_sync -> recovered bytes equal transmitted sequence for 4 frames.

Source files
------------

// File: rtl/e1_pkg.sv
// Shared E1 frame geometry and default framing words for the E1 transmit path.
// Both the framer top and its slot counter take their widths and defaults from here.
package e1_pkg;

    localparam int E1_SLOTS = 32;
    localparam int E1_BITS  = 8;
    localparam int SLOT_W   = $clog2(E1_SLOTS);
    localparam int BIT_W    = $clog2(E1_BITS);

    localparam logic [E1_BITS-1:0] FAS_DEFAULT  = 8'h1B;
    localparam logic [E1_BITS-1:0] NFAS_DEFAULT = 8'hDF;
    localparam logic [E1_BITS-1:0] IDLE_DEFAULT = 8'hFF;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(E1_SLOTS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(E1_BITS - 1);

    // Position of the line within the multiframe pair: frame parity, slot, bit.
    typedef struct packed {
        logic              odd;
        logic [SLOT_W-1:0] slot;
        logic [BIT_W-1:0]  bit_cnt;
    } e1_pos_t;

    // What the serializer does with its shift register on a given edge.
    typedef enum logic [1:0] {
        LOAD_SHIFT = 2'd0,
        LOAD_TS0   = 2'd1,
        LOAD_DATA  = 2'd2,
        LOAD_IDLE  = 2'd3
    } load_kind_t;

endpackage

// File: rtl/e1_slot_counter.sv
// Bit/slot/frame-parity counter for the E1 transmitter.
// Strobes mark the last bit of a slot and the last bit of a frame.
module e1_slot_counter
    import e1_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [BIT_W-1:0]  bit_cnt_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic              odd_o,
    output logic              slot_wrap_o,
    output logic              frame_wrap_o
);

    e1_pos_t pos_q;
    e1_pos_t pos_d;

    always_comb begin
        pos_d = pos_q;
        if (pos_q.bit_cnt == LAST_BIT) begin
            pos_d.bit_cnt = '0;
            if (pos_q.slot == LAST_SLOT) begin
                pos_d.slot = '0;
                pos_d.odd  = ~pos_q.odd;
            end else begin
                pos_d.slot = pos_q.slot + SLOT_W'(1);
            end
        end else begin
            pos_d.bit_cnt = pos_q.bit_cnt + BIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign bit_cnt_o    = pos_q.bit_cnt;
    assign slot_o       = pos_q.slot;
    assign odd_o        = pos_q.odd;
    assign slot_wrap_o  = (pos_q.bit_cnt == LAST_BIT);
    assign frame_wrap_o = (pos_q.bit_cnt == LAST_BIT) && (pos_q.slot == LAST_SLOT);

endmodule

// File: rtl/e1_framer_tx.sv
// E1 transmit framer: serializes one byte per timeslot LSB first, inserting FAS/NFAS
// in TS0 and IDLE_WORD in payload slots the source could not fill in time.
module e1_framer_tx
    import e1_pkg::*;
#(
    parameter logic [E1_BITS-1:0] FAS_WORD  = FAS_DEFAULT,
    parameter logic [E1_BITS-1:0] NFAS_WORD = NFAS_DEFAULT,
    parameter logic [E1_BITS-1:0] IDLE_WORD = IDLE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [E1_BITS-1:0] paralelo,
    input  logic               valid,
    output logic               ready,
    output logic               linha,
    output logic               frame_sync,
    output logic [SLOT_W-1:0]  slot,
    output logic               underrun
);

    // Handshake: a byte moves when valid && ready at a rising edge. ready depends
    // only on position (last bit of slots 0..30), never on valid; TS0 ignores valid.

    logic [BIT_W-1:0]   bit_cnt;
    logic               odd;
    logic               slot_wrap;
    logic               frame_wrap;

    logic [E1_BITS-1:0] sreg_q;
    logic [E1_BITS-1:0] sreg_d;
    logic               underrun_q;
    logic               underrun_d;
    load_kind_t         load_kind;

    e1_slot_counter u_slot_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .bit_cnt_o    (bit_cnt),
        .slot_o       (slot),
        .odd_o        (odd),
        .slot_wrap_o  (slot_wrap),
        .frame_wrap_o (frame_wrap)
    );

    always_comb begin
        load_kind = LOAD_SHIFT;
        if (frame_wrap) begin
            load_kind = LOAD_TS0;
        end else if (slot_wrap) begin
            load_kind = valid ? LOAD_DATA : LOAD_IDLE;
        end
    end

    // odd still describes the frame that is completing, so odd means next frame is even.
    always_comb begin
        sreg_d     = {1'b1, sreg_q[E1_BITS-1:1]};
        underrun_d = 1'b0;
        case (load_kind)
            LOAD_TS0:  sreg_d = odd ? FAS_WORD : NFAS_WORD;
            LOAD_DATA: sreg_d = paralelo;
            LOAD_IDLE: begin
                sreg_d     = IDLE_WORD;
                underrun_d = 1'b1;
            end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q     <= FAS_WORD;
            underrun_q <= 1'b0;
        end else begin
            sreg_q     <= sreg_d;
            underrun_q <= underrun_d;
        end
    end

    assign ready      = slot_wrap && !frame_wrap;
    assign linha      = sreg_q[0];
    assign frame_sync = (slot == '0) && (bit_cnt == '0);
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_e1_framer_tx.sv
// Bench for e1_framer_tx: a frame-position reference model feeds per-cycle and
// per-byte scoreboards; a monitor with a SIPO deserializer pops and compares.
module tb_e1_framer_tx;

    localparam logic [7:0] FAS  = 8'h1B;
    localparam logic [7:0] NFAS = 8'hDF;
    localparam logic [7:0] IDLE = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] paralelo = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic       linha;
    logic       frame_sync;
    logic [4:0] slot;
    logic       underrun;

    e1_framer_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .paralelo   (paralelo),
        .valid      (valid),
        .ready      (ready),
        .linha      (linha),
        .frame_sync (frame_sync),
        .slot       (slot),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       linha;
        logic       fs;
        logic [4:0] slot;
        logic       ready;
        logic       und;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_byte_q[$];

    int checks = 0;
    int failures = 0;
    bit in_reset = 1'b1;
    int und_seen = 0;
    int xfer_seen = 0;

    // Reference model: position within the 256-bit frame, frame number, current slot byte.
    int         m_pos = 0;
    int         m_frame = 0;
    logic [7:0] m_byte = FAS;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t make_rec(input logic und);
        exp_t r;
        r.linha = m_byte[3'(m_pos % 8)];
        r.fs    = (m_pos == 0);
        r.slot  = 5'(m_pos / 8);
        r.ready = (m_pos % 8 == 7) && (m_pos / 8 != 31);
        r.und   = und;
        return r;
    endfunction

    // Called at a falling edge; drives the next rising edge and predicts the cycle after it.
    task automatic step(input logic v, input logic [7:0] d);
        bit rdy;
        bit und;
        int next_pos;
        valid    = v;
        paralelo = d;
        if (v && ready) xfer_seen++;
        rdy      = (m_pos % 8 == 7) && (m_pos / 8 != 31);
        und      = 1'b0;
        next_pos = (m_pos + 1) % 256;
        if (m_pos % 8 == 7) begin
            if (next_pos / 8 == 0) begin
                m_frame++;
                m_byte = (m_frame % 2 == 0) ? FAS : NFAS;
            end else if (v && rdy) begin
                m_byte = d;
            end else begin
                m_byte = IDLE;
                und    = 1'b1;
            end
            if (m_frame >= 1) exp_byte_q.push_back(m_byte);
        end
        m_pos = next_pos;
        exp_q.push_back(make_rec(und));
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 256 && m_pos != target; i++) step(1'b0, 8'h00);
        check("run_to_position", m_pos, target);
    endtask

    task automatic step_random();
        step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)));
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset(input int hold);
        rst_n    = 1'b0;
        in_reset = 1'b1;
        valid    = 1'b0;
        exp_q.delete();
        exp_byte_q.delete();
        #1;
        check("reset_linha", linha, 1);
        check("reset_frame_sync", frame_sync, 1);
        check("reset_ready", ready, 0);
        check("reset_slot", slot, 0);
        check("reset_underrun", underrun, 0);
        repeat (hold) @(negedge clk);
        rst_n    = 1'b1;
        in_reset = 1'b0;
        m_pos    = 0;
        m_frame  = 0;
        m_byte   = FAS;
        check("release_frame_sync", frame_sync, 1);
        check("release_linha", linha, 1);
    endtask

    // Monitor: per-cycle scoreboard plus a SIPO that realigns on frame_sync.
    initial begin
        exp_t       e;
        bit         rx_active;
        int         rx_cnt;
        logic [7:0] rx_sh;
        rx_active = 1'b0;
        rx_cnt    = 0;
        rx_sh     = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (in_reset) begin
                rx_active = 1'b0;
                rx_cnt    = 0;
            end else begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty: got output with no expected entry at t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("linha", linha, e.linha);
                    check("frame_sync", frame_sync, e.fs);
                    check("slot", slot, e.slot);
                    check("ready", ready, e.ready);
                    check("underrun", underrun, e.und);
                end
                if (underrun) und_seen++;
                if (frame_sync) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
                if (rx_active) begin
                    rx_sh = {linha, rx_sh[7:1]};
                    rx_cnt++;
                    if (rx_cnt == 8) begin
                        rx_cnt = 0;
                        if (exp_byte_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL rx_byte_empty: got %0h with no expected byte at t=%0t", rx_sh, $time);
                        end else begin
                            check("rx_byte", rx_sh, exp_byte_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        int u0;
        int x0;
        @(negedge clk);
        do_reset(3);

        // Idle source: FAS/NFAS in TS0, IDLE everywhere else, 62 underruns over two frames.
        u0 = und_seen;
        repeat (512) step(1'b0, 8'h00);
        check("idle_underruns", und_seen - u0, 62);

        // Streaming source: byte k lands in slot k, 31 transfers per frame, no underrun.
        do_reset(2);
        u0 = und_seen;
        x0 = xfer_seen;
        repeat (512) step(1'b1, 8'(((m_pos / 8) + 1) % 32));
        check("stream_transfers", xfer_seen - x0, 62);
        check("stream_underruns", und_seen - u0, 0);

        // Single byte offered at slot 4 bit 7 shows in slot 5.
        run_to(39);
        step(1'b1, 8'hA5);
        repeat (12) step(1'b0, 8'h00);

        // valid held across slot 31: TS0 is not consumed, byte goes at slot 0 bit 7.
        run_to(248);
        x0 = xfer_seen;
        repeat (16) step(1'b1, 8'h3C);
        check("held_valid_transfers", xfer_seen - x0, 1);

        repeat (1200) step_random();

        // Reset mid-frame at slot 17 bit 3, then keep going past two TS0 boundaries.
        run_to(139);
        do_reset(2);
        repeat (600) step_random();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
